fifo_multichannel: RTL and testbench
====================================

FIFO_MULTICHANNEL -- requirements
Module: fifo_multichannel

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data width in bits.
REQ-002 SHALL have parameter LOG2_DEPTH, default 5: log2 of per-channel depth (DEPTH=2**LOG2_DEPTH).
REQ-003 SHALL have parameter LOG2_CHANNELS, default 2: log2 of channel count (NCH=2**LOG2_CHANNELS).
REQ-004 SHALL have parameter AF_MARGIN, default 16: almost-full asserts when count > DEPTH-AF_MARGIN.
REQ-005 SHALL have port clk, input, 1: clock; all logic on posedge only.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port we, input, 1: write request.
REQ-008 SHALL have port wchan, input, LOG2_CHANNELS: target channel of write.
REQ-009 SHALL have port wdata, input, WIDTH: write data.
REQ-010 SHALL have port re, input, 1: read request.
REQ-011 SHALL have port rchan, input, LOG2_CHANNELS: channel to read.
REQ-012 SHALL have port rvalid, output, 1: rdata/rchan_q valid this cycle.
REQ-013 SHALL have port rdata, output, WIDTH: read data.
REQ-014 SHALL have port rchan_q, output, LOG2_CHANNELS: channel that produced rdata.
REQ-015 SHALL have ports empty, full, almostfull, output, NCH each: per-channel status, bit i = channel i.
REQ-016 SHALL have port count, output, NCH*(LOG2_DEPTH+1): per-channel occupancy, channel i in slice [i*(LOG2_DEPTH+1) +: LOG2_DEPTH+1].

Function
REQ-017 SHALL store channel entries in one shared memory of NCH*DEPTH words, address {channel, pointer}.
REQ-018 SHALL keep per-channel write pointer, read pointer (LOG2_DEPTH bits, natural wrap) and count (LOG2_DEPTH+1 bits, range 0..DEPTH).
REQ-019 SHALL accept a write when we=1 and full[wchan]=0; a write to a full channel SHALL be dropped with no state change.
REQ-020 SHALL accept a read when re=1 and empty[rchan]=0; a read of an empty channel SHALL be ignored and rvalid stays 0.
REQ-021 SHALL present read data exactly 1 cycle after an accepted read: rvalid=1, rdata=oldest entry, rchan_q=rchan of the request.
REQ-022 SHALL derive empty[i]=(count==0), full[i]=(count==DEPTH), almostfull[i]=(count>DEPTH-AF_MARGIN), all combinational from registered count.
REQ-023 SHALL, on accepted write and accepted read to the same channel in one cycle, leave that count unchanged and advance both pointers.
REQ-024 SHALL, on accepted write and read to different channels, update each channel independently.
REQ-025 SHALL evaluate full/empty acceptance on pre-cycle status; a write to a full channel concurrent with a read of it SHALL still be dropped.
REQ-026 SHALL have a maximum throughput of one write and one read per cycle.

Reset
REQ-027 SHALL, while reset=1, clear all pointers and counts, drive rvalid=0, rdata=0, rchan_q=0; memory contents need not clear.
REQ-028 SHALL discard any read in flight when reset asserts; the first cycle after reset SHALL show rvalid=0, empty all ones.

Configuration
REQ-029 SHALL, with FIFO_MULTICHANNEL_ERR_EN defined, provide outputs err_overflow and err_underflow (NCH each), sticky per channel, set on dropped write/ignored read, cleared only by reset.
REQ-030 SHALL, without FIFO_MULTICHANNEL_ERR_EN, omit the error ports and their logic.

Structure
REQ-031 SHALL place channel-index and count typedefs, plus a count-slice helper function, in package pipearch_fifo_pkg.
REQ-032 SHALL instantiate sub-module bram_sdp (simple dual-port, 1-cycle registered read, parameters WIDTH, ADDR_W) for storage.

Verification
REQ-033 SHALL cover: reset, write 0xA1,0xA2 to ch1, read ch1 twice -> rdata 0xA1 then 0xA2, rchan_q=1, each 1 cycle after re; ch0/2/3 empty throughout.
REQ-034 SHALL cover: 32 writes to ch2 (default) -> full[2]=1, count[2]=32, almostfull[2] from count 17; 33rd write dropped, err_overflow[2]=1 when macro set.
REQ-035 SHALL cover: re on empty ch3 -> rvalid=0, count unchanged, err_underflow[3]=1 when macro set.
REQ-036 SHALL cover: ch0 holding 5 entries, simultaneous write+read ch0 for 40 cycles -> count[0] stays 5, data order preserved across pointer wrap.
REQ-037 SHALL cover: write ch1 and read ch0 same cycle -> count[1]+1, count[0]-1.
REQ-038 SHALL cover: reset asserted the cycle after an accepted read -> rvalid=0 next cycle, all counts 0.

Source files
------------

// File: rtl/pipearch_fifo_pkg.sv
// Shared types and helpers for the multichannel FIFO.
// The typedefs describe the default configuration (4 channels, 32-deep) and are
// handy for code that observes the FIFO. count_lsb() locates a channel's
// occupancy field inside the packed count vector for any configuration.
package pipearch_fifo_pkg;

  localparam int unsigned DefLog2Channels = 2;
  localparam int unsigned DefLog2Depth    = 5;

  typedef logic [DefLog2Channels-1:0] chan_t;
  typedef logic [DefLog2Depth:0]      cnt_t;

  // Bit offset of channel ch's occupancy field; fields are log2_depth+1 wide.
  function automatic int unsigned count_lsb(input int unsigned ch,
                                            input int unsigned log2_depth);
    return ch * (log2_depth + 1);
  endfunction

endpackage

// File: rtl/bram_sdp.sv
// Simple dual-port RAM: one write port, one read port, read data registered
// one cycle after the read enable. Only the read register is reset; memory
// contents are left as they are.
// Ports:
//   clk, reset          clock, synchronous active-high reset (clears rdata)
//   we, waddr, wdata    write port
//   re, raddr           read request; rdata valid on the following cycle
//   rdata               registered read data
module bram_sdp #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ADDR_W = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/fifo_multichannel.sv
// Multichannel FIFO: NCH independent queues sharing one memory of NCH*DEPTH
// words addressed {channel, pointer}. At most one write and one read per cycle,
// to the same or different channels. Read data appears one cycle after an
// accepted read.
// Optional feature: define FIFO_MULTICHANNEL_ERR_EN to add the sticky per-channel
// err_overflow / err_underflow outputs.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   we, wchan, wdata      write request (dropped if the channel is full)
//   re, rchan             read request (ignored if the channel is empty)
//   rvalid, rdata, rchan_q  read response, one cycle after an accepted read
//   empty, full, almostfull per-channel status, bit i = channel i
//   count                 per-channel occupancy, LOG2_DEPTH+1 bits per channel
module fifo_multichannel
  import pipearch_fifo_pkg::*;
#(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned LOG2_DEPTH    = 5,
  parameter int unsigned LOG2_CHANNELS = 2,
  parameter int unsigned AF_MARGIN     = 16
) (
  input  logic                                               clk,
  input  logic                                               reset,
  input  logic                                               we,
  input  logic [LOG2_CHANNELS-1:0]                           wchan,
  input  logic [WIDTH-1:0]                                   wdata,
  input  logic                                               re,
  input  logic [LOG2_CHANNELS-1:0]                           rchan,
  output logic                                               rvalid,
  output logic [WIDTH-1:0]                                   rdata,
  output logic [LOG2_CHANNELS-1:0]                           rchan_q,
  output logic [2**LOG2_CHANNELS-1:0]                        empty,
  output logic [2**LOG2_CHANNELS-1:0]                        full,
  output logic [2**LOG2_CHANNELS-1:0]                        almostfull,
  output logic [(2**LOG2_CHANNELS)*(LOG2_DEPTH+1)-1:0]       count
`ifdef FIFO_MULTICHANNEL_ERR_EN
  ,
  output logic [2**LOG2_CHANNELS-1:0]                        err_overflow,
  output logic [2**LOG2_CHANNELS-1:0]                        err_underflow
`endif
);

  localparam int unsigned NCH      = 2**LOG2_CHANNELS;
  localparam int unsigned DEPTH    = 2**LOG2_DEPTH;
  localparam int unsigned CW       = LOG2_DEPTH + 1;
  localparam int unsigned ADDR_W   = LOG2_CHANNELS + LOG2_DEPTH;
  // Signed so that AF_MARGIN > DEPTH simply makes almostfull always true.
  localparam int          AfThresh = int'(DEPTH) - int'(AF_MARGIN);

  logic [LOG2_DEPTH-1:0] wptr_q [NCH];
  logic [LOG2_DEPTH-1:0] wptr_d [NCH];
  logic [LOG2_DEPTH-1:0] rptr_q [NCH];
  logic [LOG2_DEPTH-1:0] rptr_d [NCH];
  logic [CW-1:0]         cnt_q  [NCH];
  logic [CW-1:0]         cnt_d  [NCH];

  logic           wr_acc, rd_acc;
  logic [NCH-1:0] wr_hit, rd_hit;
  logic [ADDR_W-1:0] waddr, raddr;

  // Status comes straight from the registered counts.
  always_comb begin
    empty      = '0;
    full       = '0;
    almostfull = '0;
    count      = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      empty[i]      = (cnt_q[i] == '0);
      full[i]       = (cnt_q[i] == CW'(DEPTH));
      almostfull[i] = (int'(cnt_q[i]) > AfThresh);
      count[count_lsb(i, LOG2_DEPTH) +: CW] = cnt_q[i];
    end
  end

  // Acceptance uses the pre-cycle status, so a write to a full channel is
  // dropped even if that channel is read in the same cycle.
  assign wr_acc = we & ~full[wchan];
  assign rd_acc = re & ~empty[rchan];
  assign wr_hit = wr_acc ? (NCH'(1) << wchan) : '0;
  assign rd_hit = rd_acc ? (NCH'(1) << rchan) : '0;

  assign waddr = {wchan, wptr_q[wchan]};
  assign raddr = {rchan, rptr_q[rchan]};

  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      wptr_d[i] = wptr_q[i];
      rptr_d[i] = rptr_q[i];
      cnt_d[i]  = cnt_q[i];
      if (wr_hit[i]) begin
        wptr_d[i] = wptr_q[i] + 1'b1;
      end
      if (rd_hit[i]) begin
        rptr_d[i] = rptr_q[i] + 1'b1;
      end
      if (wr_hit[i] && !rd_hit[i]) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end else if (!wr_hit[i] && rd_hit[i]) begin
        cnt_d[i] = cnt_q[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      rvalid  <= 1'b0;
      rchan_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        wptr_q[i] <= wptr_d[i];
        rptr_q[i] <= rptr_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
      rvalid <= rd_acc;
      if (rd_acc) begin
        rchan_q <= rchan;
      end
    end
  end

  // Same-channel read/write can never collide on an address: a read needs
  // count > 0 and a write needs count < DEPTH, so the pointers differ.
  bram_sdp #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (wr_acc),
    .waddr (waddr),
    .wdata (wdata),
    .re    (rd_acc),
    .raddr (raddr),
    .rdata (rdata)
  );

`ifdef FIFO_MULTICHANNEL_ERR_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      err_overflow  <= '0;
      err_underflow <= '0;
    end else begin
      if (we && full[wchan]) begin
        err_overflow[wchan] <= 1'b1;
      end
      if (re && empty[rchan]) begin
        err_underflow[rchan] <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_multichannel.sv
// Self-checking bench for fifo_multichannel (default parameters).
// A vector table covers reset, basic write/read, cross-channel traffic and
// reset with a read in flight; hand sequences cover fill-to-full, drain and
// pointer wrap under simultaneous write+read.
module tb_fifo_multichannel;
  import pipearch_fifo_pkg::*;

  localparam int unsigned W  = 8;
  localparam int unsigned LD = 5;
  localparam int unsigned LC = 2;
  localparam int unsigned CW = LD + 1;

  logic          clk = 1'b0;
  logic          reset, we, re;
  logic [LC-1:0] wchan, rchan;
  logic [W-1:0]  wdata;
  logic          rvalid;
  logic [W-1:0]  rdata;
  logic [LC-1:0] rchan_q;
  logic [3:0]    empty, full, almostfull;
  logic [4*CW-1:0] count;
`ifdef FIFO_MULTICHANNEL_ERR_EN
  logic [3:0]    err_overflow, err_underflow;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fifo_multichannel #(
    .WIDTH         (W),
    .LOG2_DEPTH    (LD),
    .LOG2_CHANNELS (LC),
    .AF_MARGIN     (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .we         (we),
    .wchan      (wchan),
    .wdata      (wdata),
    .re         (re),
    .rchan      (rchan),
    .rvalid     (rvalid),
    .rdata      (rdata),
    .rchan_q    (rchan_q),
    .empty      (empty),
    .full       (full),
    .almostfull (almostfull),
    .count      (count)
`ifdef FIFO_MULTICHANNEL_ERR_EN
    ,
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow)
`endif
  );

  typedef struct {
    logic          rst;
    logic          we;
    logic [1:0]    wchan;
    logic [7:0]    wdata;
    logic          re;
    logic [1:0]    rchan;
    logic          e_rvalid;
    logic [7:0]    e_rdata;
    logic [1:0]    e_rchan;
    logic [23:0]   e_count;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(input logic rst, input logic w, input logic [1:0] wc,
                              input logic [7:0] wd, input logic r, input logic [1:0] rc,
                              input logic erv, input logic [7:0] erd, input logic [1:0] erc,
                              input int c0, input int c1, input int c2, input int c3);
    vec_t v;
    v.rst = rst; v.we = w; v.wchan = wc; v.wdata = wd; v.re = r; v.rchan = rc;
    v.e_rvalid = erv; v.e_rdata = erd; v.e_rchan = erc;
    v.e_count = {6'(c3), 6'(c2), 6'(c1), 6'(c0)};
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic cnt_t cnt_of(input int ch);
    return count[ch*6 +: 6];
  endfunction

  task automatic drive(input logic rst, input logic w, input logic [1:0] wc,
                       input logic [7:0] wd, input logic r, input logic [1:0] rc);
    reset = rst; we = w; wchan = wc; wdata = wd; re = r; rchan = rc;
  endtask

  // Advance one clock and sample just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] model_q[$];
  logic [7:0] exp_d;
  logic [3:0] exp_empty;

  initial begin
    drive(1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0);

    // ---------------- table-driven vectors ----------------
    vecs[0]  = mk(1, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 1, 1, 8'hA1, 0, 0, 0, 8'h00, 0, 0, 1, 0, 0);
    vecs[2]  = mk(0, 1, 1, 8'hA2, 0, 0, 0, 8'h00, 0, 0, 2, 0, 0);
    vecs[3]  = mk(0, 0, 0, 8'h00, 1, 1, 1, 8'hA1, 1, 0, 1, 0, 0);
    vecs[4]  = mk(0, 0, 0, 8'h00, 1, 1, 1, 8'hA2, 1, 0, 0, 0, 0);
    vecs[5]  = mk(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0);
    vecs[6]  = mk(0, 0, 0, 8'h00, 1, 3, 0, 8'h00, 0, 0, 0, 0, 0);
    vecs[7]  = mk(0, 1, 0, 8'h10, 0, 0, 0, 8'h00, 0, 1, 0, 0, 0);
    vecs[8]  = mk(0, 1, 0, 8'h11, 0, 0, 0, 8'h00, 0, 2, 0, 0, 0);
    vecs[9]  = mk(0, 1, 1, 8'h20, 1, 0, 1, 8'h10, 0, 1, 1, 0, 0);
    vecs[10] = mk(0, 0, 0, 8'h00, 1, 0, 1, 8'h11, 0, 0, 1, 0, 0);
    vecs[11] = mk(0, 1, 2, 8'h30, 0, 0, 0, 8'h00, 0, 0, 1, 1, 0);
    vecs[12] = mk(0, 1, 2, 8'h31, 0, 0, 0, 8'h00, 0, 0, 1, 2, 0);
    vecs[13] = mk(0, 0, 0, 8'h00, 1, 2, 1, 8'h30, 2, 0, 1, 1, 0);
    vecs[14] = mk(1, 0, 0, 8'h00, 1, 1, 0, 8'h00, 0, 0, 0, 0, 0);
    vecs[15] = mk(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0);

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].rst, vecs[i].we, vecs[i].wchan, vecs[i].wdata, vecs[i].re, vecs[i].rchan);
      step();
      for (int c = 0; c < 4; c++) exp_empty[c] = (vecs[i].e_count[c*6 +: 6] == 6'd0);
      chk($sformatf("v%0d rvalid", i), 32'(rvalid), 32'(vecs[i].e_rvalid));
      chk($sformatf("v%0d count", i), 32'(count), 32'(vecs[i].e_count));
      chk($sformatf("v%0d empty", i), 32'(empty), 32'(exp_empty));
      chk($sformatf("v%0d full", i), 32'(full), 32'h0);
      if (vecs[i].e_rvalid || vecs[i].rst) begin
        chk($sformatf("v%0d rdata", i), 32'(rdata), 32'(vecs[i].e_rdata));
        chk($sformatf("v%0d rchan_q", i), 32'(rchan_q), 32'(vecs[i].e_rchan));
      end
    end

    // ---------------- fill ch2 to full, overflow, drain ----------------
    drive(1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0);
    step();
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 1'b1, 2'd2, 8'(i), 1'b0, 2'd0);
      step();
      chk($sformatf("fill%0d count2", i), 32'(cnt_of(2)), 32'(i + 1));
      chk($sformatf("fill%0d af2", i), 32'(almostfull[2]), 32'((i + 1) > 16));
      chk($sformatf("fill%0d full2", i), 32'(full[2]), 32'((i + 1) == 32));
    end
    drive(1'b0, 1'b1, 2'd2, 8'hEE, 1'b0, 2'd0);
    step();
    chk("overflow count2", 32'(cnt_of(2)), 32'd32);
    chk("overflow full", 32'(full), 32'h4);
    chk("overflow af", 32'(almostfull), 32'h4);
`ifdef FIFO_MULTICHANNEL_ERR_EN
    chk("err_overflow", 32'(err_overflow), 32'h4);
`endif
    // Write to a full channel with a concurrent read of it is still dropped.
    drive(1'b0, 1'b1, 2'd2, 8'hFF, 1'b1, 2'd2);
    step();
    chk("fullrw rvalid", 32'(rvalid), 32'd1);
    chk("fullrw rdata", 32'(rdata), 32'h00);
    chk("fullrw count2", 32'(cnt_of(2)), 32'd31);
    for (int i = 1; i < 32; i++) begin
      drive(1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 2'd2);
      step();
      chk($sformatf("drain%0d rvalid", i), 32'(rvalid), 32'd1);
      chk($sformatf("drain%0d rdata", i), 32'(rdata), 32'(i));
    end
    chk("drained empty", 32'(empty), 32'hF);
    // Read of empty ch3.
    drive(1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 2'd3);
    step();
    chk("underflow rvalid", 32'(rvalid), 32'd0);
    chk("underflow count", 32'(count), 32'h0);
`ifdef FIFO_MULTICHANNEL_ERR_EN
    chk("err_underflow", 32'(err_underflow), 32'h8);
    chk("err_overflow kept", 32'(err_overflow), 32'h4);
`endif

    // ---------------- ch0 steady state with pointer wrap ----------------
    drive(1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0);
    step();
    model_q.delete();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 2'd0, 8'(8'h40 + i), 1'b0, 2'd0);
      model_q.push_back(8'(8'h40 + i));
      step();
    end
    chk("pre-wrap count0", 32'(cnt_of(0)), 32'd5);
    for (int k = 0; k < 40; k++) begin
      drive(1'b0, 1'b1, 2'd0, 8'(8'h80 + k), 1'b1, 2'd0);
      exp_d = model_q.pop_front();
      model_q.push_back(8'(8'h80 + k));
      step();
      chk($sformatf("wrap%0d rvalid", k), 32'(rvalid), 32'd1);
      chk($sformatf("wrap%0d rdata", k), 32'(rdata), 32'(exp_d));
      chk($sformatf("wrap%0d count0", k), 32'(cnt_of(0)), 32'd5);
    end
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 2'd0);
      exp_d = model_q.pop_front();
      step();
      chk($sformatf("tail%0d rdata", k), 32'(rdata), 32'(exp_d));
      chk($sformatf("tail%0d rchan_q", k), 32'(rchan_q), 32'd0);
    end
    chk("final empty", 32'(empty), 32'hF);

    drive(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0);
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
